// File: rtl/ldo_ramp_sequencer.sv
// rtl/ldo_ramp_sequencer.sv - bounded-step DAC ramp sequencer feeding the SPI master command FIFO
// Walks enabled channels in passes, issuing one clamped code update per channel per pass.
module ldo_ramp_sequencer #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 11,
    parameter int INIT_CODE = 0,
    parameter int MAX_CODE  = 2047
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [NUM_CH-1:0]          ch_en_i,
    input  logic [NUM_CH*DATA_W-1:0]   target_i,
    input  logic [DATA_W-1:0]          step_i,
    input  logic [15:0]                interval_i,
    input  logic                       fifo_full_i,
    output logic                       wr_en_o,
    output logic [31:0]                wr_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [NUM_CH*DATA_W-1:0]   cur_code_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DATA_W-1:0] MAX_C  = DATA_W'(MAX_CODE);
    localparam logic [DATA_W-1:0] INIT_C = DATA_W'(INIT_CODE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       pend_q;
    logic [15:0]                cnt_q;
    logic [NUM_CH-1:0]          en_q;
    logic [NUM_CH*DATA_W-1:0]   tgt_q;
    logic [NUM_CH*DATA_W-1:0]   cur_q;
    logic [DATA_W-1:0]          step_q;
    logic [15:0]                interval_q;
    logic                       wr_en_q;
    logic [31:0]                wr_data_q;
    logic                       busy_q;
    logic                       done_q;

    logic [NUM_CH*DATA_W-1:0]   tgt_clamp_d;
    logic [DATA_W-1:0]          cur_sel;
    logic [DATA_W-1:0]          tgt_sel;
    logic [DATA_W:0]            sum_w;
    logic [DATA_W:0]            diff_w;
    logic [DATA_W-1:0]          nxt_d;
    logic                       need_move;
    logic                       last_idx;
    logic                       pend_d;
    logic                       pass_pend;
    logic [31:0]                word_d;

    always_comb begin
        tgt_clamp_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_clamp_d[i*DATA_W +: DATA_W] =
                (target_i[i*DATA_W +: DATA_W] > MAX_C) ? MAX_C : target_i[i*DATA_W +: DATA_W];
        end
    end

    // Step arithmetic carries one extra bit so neither direction can wrap past the target.
    always_comb begin
        cur_sel   = cur_q[idx_q*DATA_W +: DATA_W];
        tgt_sel   = tgt_q[idx_q*DATA_W +: DATA_W];
        need_move = en_q[idx_q] && (cur_sel != tgt_sel);
        last_idx  = (idx_q == LAST_IDX);
        sum_w     = {1'b0, cur_sel} + {1'b0, step_q};
        diff_w    = {1'b0, cur_sel} - {1'b0, step_q};
        if (cur_sel < tgt_sel) begin
            nxt_d = (sum_w > {1'b0, tgt_sel}) ? tgt_sel : sum_w[DATA_W-1:0];
        end else if (cur_sel > tgt_sel) begin
            nxt_d = (diff_w[DATA_W] || (diff_w[DATA_W-1:0] < tgt_sel)) ? tgt_sel : diff_w[DATA_W-1:0];
        end else begin
            nxt_d = cur_sel;
        end
        pend_d    = pend_q | (nxt_d != tgt_sel);
        pass_pend = (state_q == S_WRITE) ? pend_d : pend_q;
        word_d    = '0;
        word_d[16 +: DATA_W] = nxt_d;
        word_d[7:0]          = 8'd1 << idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            en_q       <= '0;
            tgt_q      <= '0;
            cur_q      <= {NUM_CH{INIT_C}};
            step_q     <= '0;
            interval_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                if (start_i && !abort_i) begin
                    en_q       <= ch_en_i;
                    tgt_q      <= tgt_clamp_d;
                    step_q     <= (step_i == '0) ? DATA_W'(1) : step_i;
                    interval_q <= interval_i;
                    idx_q      <= '0;
                    pend_q     <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= S_CHECK;
                end
            end else if (abort_i) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_CHECK, S_WRITE: begin
                        if (state_q == S_CHECK && need_move) begin
                            state_q <= S_WRITE;
                        end else if (!(state_q == S_WRITE && fifo_full_i)) begin
                            if (state_q == S_WRITE) begin
                                wr_en_q                         <= 1'b1;
                                wr_data_q                       <= word_d;
                                cur_q[idx_q*DATA_W +: DATA_W]   <= nxt_d;
                                pend_q                          <= pend_d;
                            end
                            if (!last_idx) begin
                                idx_q   <= idx_q + IDX_W'(1);
                                state_q <= S_CHECK;
                            end else if (!pass_pend) begin
                                state_q <= S_DONE;
                            end else if (interval_q == 16'd0) begin
                                idx_q   <= '0;
                                pend_q  <= 1'b0;
                                state_q <= S_CHECK;
                            end else begin
                                cnt_q   <= interval_q - 16'd1;
                                state_q <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (cnt_q == 16'd0) begin
                            idx_q   <= '0;
                            pend_q  <= 1'b0;
                            state_q <= S_CHECK;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cur_code_o = cur_q;

endmodule
